checkpoint_seq_monitor: RTL
===========================

// Module: checkpoint_seq_monitor
// PURPOSE
//  Synthesizable, parametrised monitor for firmware progress codes on the mprj_io check field.
//  Waits for NUM_CKPT codes CODE_BASE, CODE_BASE+1, ... in order, with per-code stability filtering.
//  Flags PASS, FAIL or TIMEOUT and records the elapsed cycle count.
//  Sits in the user project next to btc_miner_top as an on-chip self-test verdict block.
// PARAMETERS
//  WIDTH           16        width of watched code field
//  NUM_CKPT        2         number of checkpoints in sequence (1..16)
//  CODE_BASE       16'hAB60  code of checkpoint 0; checkpoint i = CODE_BASE+i (mod 2^WIDTH)
//  STABLE_CYCLES   2         consecutive sampled cycles a value must hold to count (>=1)
//  TIMEOUT_CYCLES  220000    cycle budget from arm to final checkpoint (>=2)
// PORTS
//  wb_clk_i     in   1                    clock
//  wb_rst_i     in   1                    async active-high reset
//  enable_i     in   1                    arm monitor; low returns to IDLE
//  strict_i     in   1                    1: unexpected stable code => FAIL
//  watch_i      in   WIDTH                code field (mprj_io[31:16])
//  busy_o       out  1                    ARMED or RUN
//  pass_o       out  1                    sticky pass
//  fail_o       out  1                    sticky fail (strict violation or timeout)
//  timeout_o    out  1                    sticky, fail cause = timeout
//  stage_o      out  $clog2(NUM_CKPT+1)   checkpoints accepted so far
//  cycles_o     out  $clog2(TIMEOUT_CYCLES+1)  elapsed cycles; frozen at PASS/FAIL
//  fail_code_o  out  WIDTH                offending stable code (strict fail), else 0
//  trace_sel_i  in   $clog2(NUM_CKPT)     trace index (see CONFIGURATION)
//  trace_ts_o   out  $clog2(TIMEOUT_CYCLES+1)  cycles_o value when checkpoint trace_sel_i was accepted
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; filter counter and sample register cleared.
//  - watch_i registered once (sample). Filter: stable_cnt++ while sample == previous sample
//    (saturates at STABLE_CYCLES); otherwise reloads 1. "Stable value" = sample with stable_cnt == STABLE_CYCLES.
//  - Latency: a code held from cycle t is accepted at rising edge t+STABLE_CYCLES+1.
//  - FSM: IDLE -(enable_i)-> ARMED. ARMED -(stable == CODE_BASE)-> RUN, stage = 1.
//    RUN -(stable == CODE_BASE+stage)-> stage++; last accept -> PASS.
//    If NUM_CKPT==1, ARMED goes directly to PASS.
//  - Each code is accepted exactly once; a held code does not re-trigger the next stage.
//  - Strict (strict_i=1): in RUN, a stable value that differs from both last accepted and expected code
//    -> FAIL, fail_code_o = that value. In ARMED, strict is ignored (bus holds junk before firmware runs).
//  - cycles_o counts +1 per cycle in ARMED/RUN, starting at 0 on entry to ARMED.
//    When it reaches TIMEOUT_CYCLES-1 without completion -> FAIL, timeout_o=1.
//  - Simultaneous final accept and timeout in the same cycle: PASS wins. Strict fail and timeout together: timeout_o=1, fail_code_o still captured.
//  - PASS/FAIL are sticky while enable_i=1.
//  - enable_i=0 in any state -> IDLE next cycle; pass/fail/timeout/stage/cycles/fail_code cleared. Re-arm needs enable_i 0->1.
//  - busy_o = (state==ARMED || state==RUN), registered.
//  - Reset mid-run aborts immediately to IDLE; no partial verdict retained.
// CONFIGURATION
//  CKPT_MON_TRACE_EN defined: NUM_CKPT-entry timestamp array; entry i <= cycles_o on checkpoint i accept.
//    trace_ts_o = array[trace_sel_i], registered, 1-cycle latency. Cleared on reset and on IDLE.
//  Undefined: no array; trace_ts_o tied 0; trace_sel_i ignored. Ports always present.
// STRUCTURE
//  - Package ckpt_mon_pkg: state enum (IDLE, ARMED, RUN, PASS, FAIL) and default CODE_BASE / WIDTH constants.
//  - Sub-module ckpt_stable_filter (WIDTH, STABLE_CYCLES): sample register + stability counter; outputs stable_valid, stable_val.
//  - Top: FSM, stage counter, cycle counter, optional trace array.
// TESTING  (WIDTH=16, CODE_BASE=16'hAB60, NUM_CKPT=2, STABLE_CYCLES=2, TIMEOUT_CYCLES=1000)
//  1. Arm; hold AB60 for 5 cycles, then AB61 for 5 cycles -> stage 1 then 2; pass_o=1, fail_o=0, busy_o=0.
//  2. Arm; AB60 held, then AB61 for 1 cycle only, then back to AB60 -> no advance; at cycle 999, fail_o=timeout_o=1, stage_o=1.
//  3. strict_i=1; AB60, then stable 1234 -> fail_o=1, fail_code_o=16'h1234, timeout_o=0.
//     Repeat with strict_i=0 -> no fail.
//  4. Final AB61 accepted on the same cycle cycles_o hits 999 -> pass_o=1, timeout_o=0.
//  5. Assert wb_rst_i mid-RUN (stage 1) -> all outputs 0 immediately. enable_i low 1 cycle -> IDLE, cycles_o=0.
//  6. CKPT_MON_TRACE_EN: AB60 from cycle 10, AB61 from cycle 40 after arm -> trace_ts_o[0]=13, [1]=43.

Source files
------------

// File: rtl/ckpt_mon_pkg.sv
// ============================================================================
// Module : ckpt_mon_pkg
// Shared state encoding and default code-field constants for the monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ckpt_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } ckpt_state_e;

  localparam int          C_DEF_WIDTH     = 16;
  localparam logic [15:0] C_DEF_CODE_BASE = 16'hAB60;

endpackage

`default_nettype wire

// File: rtl/ckpt_stable_filter.sv
// ============================================================================
// Module : ckpt_stable_filter
// Registers the watched code and reports it once held for STABLE_CYCLES samples.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ckpt_stable_filter #(
  parameter  int WIDTH         = 16,
  parameter  int STABLE_CYCLES = 2,
  localparam int CNTW          = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_watch,
  output logic             o_stable_valid,
  output logic [WIDTH-1:0] o_stable_val
);

  logic [WIDTH-1:0] r_sample;
  logic [CNTW-1:0]  r_cnt;

  // Counter tracks how many consecutive samples equal the current r_sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= '0;
      r_cnt    <= '0;
    end else begin
      r_sample <= i_watch;
      if (i_watch != r_sample) begin
        r_cnt <= CNTW'(1);
      end else if (r_cnt != CNTW'(STABLE_CYCLES)) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

  assign o_stable_valid = (r_cnt == CNTW'(STABLE_CYCLES));
  assign o_stable_val   = r_sample;

endmodule

`default_nettype wire

// File: rtl/checkpoint_seq_monitor.sv
// ============================================================================
// Module : checkpoint_seq_monitor
// Ordered progress-code checker with PASS/FAIL/TIMEOUT verdict and cycle count.
// Optional per-checkpoint timestamp trace: define CKPT_MON_TRACE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module checkpoint_seq_monitor
  import ckpt_mon_pkg::*;
#(
  parameter  int               WIDTH          = C_DEF_WIDTH,
  parameter  int               NUM_CKPT       = 2,
  parameter  logic [WIDTH-1:0] CODE_BASE      = WIDTH'(C_DEF_CODE_BASE),
  parameter  int               STABLE_CYCLES  = 2,
  parameter  int               TIMEOUT_CYCLES = 220000,
  localparam int               SW             = $clog2(NUM_CKPT + 1),
  localparam int               CW             = $clog2(TIMEOUT_CYCLES + 1),
  localparam int               SELW           = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable_i,
  input  logic             strict_i,
  input  logic [WIDTH-1:0] watch_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [SW-1:0]    stage_o,
  output logic [CW-1:0]    cycles_o,
  output logic [WIDTH-1:0] fail_code_o,
  input  logic [SELW-1:0]  trace_sel_i,
  output logic [CW-1:0]    trace_ts_o
);

  ckpt_state_e      r_state;
  logic             r_busy;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic [SW-1:0]    r_stage;
  logic [CW-1:0]    r_cycles;
  logic [WIDTH-1:0] r_fail_code;

  logic             w_stable_valid;
  logic [WIDTH-1:0] w_stable_val;
  logic [WIDTH-1:0] w_expected;
  logic [WIDTH-1:0] w_last_code;
  logic             w_active;
  logic             w_last;
  logic             w_timeout;
  logic             w_take;
  logic             w_strict_hit;
  logic [CW-1:0]    w_cyc_next;

  ckpt_stable_filter #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk            (wb_clk_i),
    .rst            (wb_rst_i),
    .i_watch        (watch_i),
    .o_stable_valid (w_stable_valid),
    .o_stable_val   (w_stable_val)
  );

  assign w_expected  = CODE_BASE + WIDTH'(r_stage);
  assign w_last_code = w_expected - WIDTH'(1);
  assign w_active    = (r_state == ST_ARMED) || (r_state == ST_RUN);
  assign w_last      = (r_stage == SW'(NUM_CKPT - 1));
  assign w_cyc_next  = r_cycles + CW'(1);
  // The edge that moves cycles_o onto TIMEOUT_CYCLES-1 is the expiry edge.
  assign w_timeout   = (r_cycles == CW'(TIMEOUT_CYCLES - 2));
  // A final accept beats a coincident timeout; earlier accepts do not.
  assign w_take      = enable_i && w_active && w_stable_valid &&
                       (w_stable_val == w_expected) && (w_last || !w_timeout);
  assign w_strict_hit = (r_state == ST_RUN) && strict_i && w_stable_valid &&
                        (w_stable_val != w_expected) && (w_stable_val != w_last_code);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_stage     <= '0;
      r_cycles    <= '0;
      r_fail_code <= '0;
    end else if (!enable_i) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_stage     <= '0;
      r_cycles    <= '0;
      r_fail_code <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state  <= ST_ARMED;
          r_busy   <= 1'b1;
          r_cycles <= '0;
        end
        ST_ARMED, ST_RUN: begin
          r_cycles <= w_cyc_next;
          if (w_take) begin
            r_stage <= r_stage + SW'(1);
            if (w_last) begin
              r_state <= ST_PASS;
              r_busy  <= 1'b0;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end else if (w_timeout) begin
            r_state   <= ST_FAIL;
            r_busy    <= 1'b0;
            r_fail    <= 1'b1;
            r_timeout <= 1'b1;
            if (w_strict_hit) begin
              r_fail_code <= w_stable_val;
            end
          end else if (w_strict_hit) begin
            r_state     <= ST_FAIL;
            r_busy      <= 1'b0;
            r_fail      <= 1'b1;
            r_fail_code <= w_stable_val;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign timeout_o   = r_timeout;
  assign stage_o     = r_stage;
  assign cycles_o    = r_cycles;
  assign fail_code_o = r_fail_code;

`ifdef CKPT_MON_TRACE_EN
  logic [CW-1:0] r_trace [NUM_CKPT];
  logic [CW-1:0] r_trace_ts;
  logic [CW-1:0] w_trace_rd;

  always_comb begin
    w_trace_rd = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (trace_sel_i == SELW'(i)) begin
        w_trace_rd = r_trace[i];
      end
    end
  end

  // Each entry holds the cycles_o value produced by its accepting edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        r_trace[i] <= '0;
      end
      r_trace_ts <= '0;
    end else if (!enable_i || (r_state == ST_IDLE)) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        r_trace[i] <= '0;
      end
      r_trace_ts <= '0;
    end else begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (w_take && (r_stage == SW'(i))) begin
          r_trace[i] <= w_cyc_next;
        end
      end
      r_trace_ts <= w_trace_rd;
    end
  end

  assign trace_ts_o = r_trace_ts;
`else
  logic w_unused_sel;
  assign w_unused_sel = ^trace_sel_i;
  assign trace_ts_o   = '0;
`endif

endmodule

`default_nettype wire
